// File: rtl/store_pkg.sv
// Shared types for the store-path controller.
// Build option: STORE_SPLIT_EN adds the second-beat states used for word-crossing stores.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } st_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND0,
        ST_RESP0
`ifdef STORE_SPLIT_EN
        ,
        ST_SEND1,
        ST_RESP1
`endif
    } st_state_e;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // Byte-lane enables for a store of the given size starting at lane 0.
    function automatic logic [3:0] base_strobe(input st_size_e size);
        case (size)
            SZ_BYTE: base_strobe = 4'b0001;
            SZ_HALF: base_strobe = 4'b0011;
            SZ_WORD: base_strobe = 4'b1111;
            default: base_strobe = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Byte-lane alignment of store strobe and data over a two-word window.
// Build option: none (used unchanged with or without STORE_SPLIT_EN).
module store_lane_gen
    import store_pkg::*;
(
    input  logic [1:0]  off,
    input  st_size_e    size,
    input  logic [31:0] data,
    output logic [3:0]  strb0,
    output logic [3:0]  strb1,
    output logic [31:0] data0,
    output logic [31:0] data1,
    output logic        split
);

    logic [6:0]  s7;
    logic [63:0] d64;

    // Shift strobe and data up by the byte offset; anything past lane 3 spills into the next word.
    always_comb begin
        s7    = {3'b000, base_strobe(size)} << off;
        d64   = {32'b0, data} << {off, 3'b000};
        strb0 = s7[3:0];
        strb1 = {1'b0, s7[6:4]};
        data0 = d64[31:0];
        data1 = d64[63:32];
        split = |s7[6:4];
    end

endmodule

// File: rtl/store_split_ctrl.sv
// Store-path controller: aligns a CPU store onto a word-aligned write port
// and reports done / error / misalignment with one-cycle pulses.
// Build option: STORE_SPLIT_EN splits word-crossing stores into two beats;
// without it such stores are rejected with st_misalign.
module store_split_ctrl
    import store_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 0,
    parameter int unsigned TO_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        st_err,
    output logic        st_misalign,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_bvalid,
    input  logic [1:0]  m_bresp,
    output logic        m_bready
);

    st_state_e       state, state_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic [31:0]     req_addr, req_data;
    st_size_e        req_size;
    logic            alive;
    logic            accept;
    logic            done_nxt, err_nxt;
`ifndef STORE_SPLIT_EN
    logic            mis_nxt;
`endif

    logic [1:0]  lg_off;
    st_size_e    lg_size;
    logic [31:0] lg_data;
    logic [3:0]  strb0, strb1;
    logic [31:0] data0, data1;
    logic        split;

    // alive keeps st_ready low while reset is held, so every output reads 0 in reset.
    assign st_ready = alive && (state == ST_IDLE);
    assign accept   = st_valid && st_ready;

    // One lane generator: in IDLE it sees the incoming request (for the split decision),
    // afterwards the registered request (for the beats).
    always_comb begin
        if (state == ST_IDLE) begin
            lg_off  = st_addr[1:0];
            lg_size = st_size_e'(st_size);
            lg_data = st_data;
        end else begin
            lg_off  = req_addr[1:0];
            lg_size = req_size;
            lg_data = req_data;
        end
    end

    store_lane_gen u_lane (
        .off   (lg_off),
        .size  (lg_size),
        .data  (lg_data),
        .strb0 (strb0),
        .strb1 (strb1),
        .data0 (data0),
        .data1 (data1),
        .split (split)
    );

`ifdef STORE_SPLIT_EN
    assign st_misalign = 1'b0;
`else
    logic unused_hi;
    assign unused_hi = ^{strb1, data1};
`endif

    // State, timeout counter, captured request and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            alive    <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            req_size <= SZ_BYTE;
            st_done  <= 1'b0;
            st_err   <= 1'b0;
`ifndef STORE_SPLIT_EN
            st_misalign <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            alive   <= 1'b1;
            st_done <= done_nxt;
            st_err  <= err_nxt;
`ifndef STORE_SPLIT_EN
            st_misalign <= mis_nxt;
`endif
            if (accept) begin
                req_addr <= st_addr;
                req_data <= st_data;
                req_size <= st_size_e'(st_size);
            end
        end
    end

    // Next-state, counter and bus-side outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifndef STORE_SPLIT_EN
        mis_nxt   = 1'b0;
`endif
        m_valid   = 1'b0;
        m_bready  = 1'b0;
        m_addr    = '0;
        m_wstrb   = '0;
        m_wdata   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (lg_size == SZ_ILL) begin
                        err_nxt = 1'b1;
                    end else if (split) begin
`ifdef STORE_SPLIT_EN
                        state_nxt = ST_SEND0;
`else
                        mis_nxt = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_SEND0;
                    end
                end
            end
            ST_SEND0: begin
                m_valid = 1'b1;
                m_addr  = {req_addr[31:2], 2'b00};
                m_wstrb = strb0;
                m_wdata = data0;
                if (m_ready) begin
                    state_nxt = ST_RESP0;
                    cnt_nxt   = '0;
                end
            end
`ifdef STORE_SPLIT_EN
            ST_SEND1: begin
                m_valid = 1'b1;
                m_addr  = {req_addr[31:2] + 30'd1, 2'b00};
                m_wstrb = strb1;
                m_wdata = data1;
                if (m_ready) begin
                    state_nxt = ST_RESP1;
                    cnt_nxt   = '0;
                end
            end
            ST_RESP0, ST_RESP1: begin
`else
            ST_RESP0: begin
`endif
                m_bready = 1'b1;
                if (m_bvalid) begin
                    if (m_bresp != BRESP_OKAY) begin
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end
`ifdef STORE_SPLIT_EN
                    else if (state == ST_RESP0 && split) begin
                        state_nxt = ST_SEND1;
                    end
`endif
                    else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (RESP_TIMEOUT != 0) begin
                    // cnt counts completed RESP cycles; the limit is hit on the last allowed one.
                    if (cnt == TO_W'(RESP_TIMEOUT - 1)) begin
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + TO_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_split_ctrl.sv
// Self-checking bench for store_split_ctrl: directed cases plus randomized stores
// checked against a byte-by-byte memory-write model.
module tb_store_split_ctrl;

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_size;
    logic        st_done, st_err, st_misalign;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;

    int errors = 0;
    int checks = 0;

    store_split_ctrl #(.RESP_TIMEOUT(TO), .TO_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_size     (st_size),
        .st_data     (st_data),
        .st_done     (st_done),
        .st_err      (st_err),
        .st_misalign (st_misalign),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_wstrb     (m_wstrb),
        .m_wdata     (m_wdata),
        .m_bvalid    (m_bvalid),
        .m_bresp     (m_bresp),
        .m_bready    (m_bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {st_ready, st_done, st_err, st_misalign, m_valid, m_bready, m_wstrb}, '0);
        check({tag, "_addr"}, m_addr, '0);
        check({tag, "_data"}, m_wdata, '0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (st_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("ready_wait", st_ready, 1'b1);
    endtask

    // CPU and memory roles for one store; expected beats come from placing each byte
    // of the store at its own address and grouping by 32-bit word.
    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data_in,
                            input int rwait, input int bwait, input logic [1:0] resp0, input logic [1:0] resp1);
        int          n;
        int          nb;
        logic [31:0] data;
        logic [31:0] w0;
        logic [31:0] ea [2];
        logic [3:0]  es [2];
        logic [31:0] ed [2];
        logic [1:0]  r;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        data = (n == 4) ? data_in : (data_in & ((32'd1 << (8 * n)) - 32'd1));
        w0   = addr & 32'hFFFF_FFFC;
        ea[0] = w0;
        ea[1] = w0 + 32'd4;
        es[0] = '0; es[1] = '0; ed[0] = '0; ed[1] = '0;
        nb = 1;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            int          b;
            a = addr + 32'(i);
            b = ((a & 32'hFFFF_FFFC) == w0) ? 0 : 1;
            if (b == 1) nb = 2;
            es[b][a[1:0]] = 1'b1;
            ed[b][8 * a[1:0] +: 8] = data[8 * i +: 8];
        end

        wait_ready();
        st_valid = 1'b1;
        st_addr  = addr;
        st_size  = size;
        st_data  = data;
        step();
        st_valid = 1'b0;
        st_addr  = $urandom;
        st_size  = 2'($urandom);
        st_data  = $urandom;

        if (size == 2'b11) begin
            check("ill_pulses", {st_done, st_err, st_misalign}, 3'b010);
            check("ill_nobus", m_valid, 1'b0);
            check("ill_ready", st_ready, 1'b1);
            return;
        end
        if (nb == 2 && !SPLIT_EN) begin
            check("mis_pulses", {st_done, st_err, st_misalign}, 3'b001);
            check("mis_nobus", m_valid, 1'b0);
            return;
        end
        check("t1_pulses", {st_done, st_err, st_misalign}, 3'b000);

        for (int b = 0; b < nb; b++) begin
            check("beat_valid", m_valid, 1'b1);
            check("beat_addr", m_addr, ea[b]);
            check("beat_strb", m_wstrb, es[b]);
            check("beat_data", m_wdata, ed[b]);
            for (int k = 0; k < rwait; k++) begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b10;
                step();
                check("hold_ctl", {m_valid, m_bready, m_wstrb}, {1'b1, 1'b0, es[b]});
                check("hold_addr", m_addr, ea[b]);
                check("hold_data", m_wdata, ed[b]);
            end
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
            m_ready  = 1'b1;
            step();
            m_ready = 1'b0;
            check("resp_state", {m_valid, m_bready}, 2'b01);
            for (int k = 0; k < bwait; k++) step();
            r = (b == 0) ? resp0 : resp1;
            m_bvalid = 1'b1;
            m_bresp  = r;
            step();
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
            if (r != 2'b00) begin
                check("berr_pulses", {st_done, st_err, st_misalign}, 3'b010);
                check("berr_idle", {m_valid, m_bready, st_ready}, 3'b001);
                return;
            end
            if (b == nb - 1) begin
                check("done_pulses", {st_done, st_err, st_misalign}, 3'b100);
                check("done_idle", {m_valid, m_bready, st_ready}, 3'b001);
            end
        end
    endtask

    task automatic do_timeout(input bit race);
        wait_ready();
        st_valid = 1'b1;
        st_addr  = 32'h0000_0040;
        st_size  = 2'b10;
        st_data  = 32'h1111_2222;
        step();
        st_valid = 1'b0;
        check("to_send", m_valid, 1'b1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        for (int k = 0; k < TO - 1; k++) begin
            check("to_wait", {m_bready, st_err, st_done}, 3'b100);
            step();
        end
        check("to_last", {m_bready, st_err}, 2'b10);
        if (race) begin
            m_bvalid = 1'b1;
            m_bresp  = 2'b00;
            step();
            m_bvalid = 1'b0;
            check("to_race", {st_done, st_err}, 2'b10);
        end else begin
            step();
            check("to_expire", {st_done, st_err, m_bready}, 3'b010);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_size  = '0;
        st_data  = '0;
        m_ready  = 1'b0;
        m_bvalid = 1'b0;
        m_bresp  = '0;
        #2;
        check_all_zero("reset");
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();
        check("ready_after_reset", st_ready, 1'b1);

        do_store(32'h0000_0100, 2'b10, 32'hDEAD_BEEF, 0, 0, 2'b00, 2'b00);
        do_store(32'h0000_0103, 2'b00, 32'h0000_00AB, 1, 2, 2'b00, 2'b00);
        do_store(32'h0000_0203, 2'b01, 32'h0000_1234, 0, 1, 2'b00, 2'b00);
        do_store(32'hFFFF_FFFE, 2'b10, 32'hCAFE_F00D, 2, 0, 2'b00, 2'b00);
        do_store(32'h0000_0203, 2'b01, 32'h0000_5678, 0, 0, 2'b10, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_reissue", m_valid, 1'b0);
        end
        check("ready_back", st_ready, 1'b1);
        do_store(32'h0000_0010, 2'b11, 32'h0BAD_0BAD, 0, 0, 2'b00, 2'b00);
        step();
        check("ill_one_cycle", st_err, 1'b0);
        do_timeout(1'b0);
        do_timeout(1'b1);

        // Async reset with a beat on the bus (second beat when splitting is built in).
        wait_ready();
        st_valid = 1'b1;
        st_addr  = SPLIT_EN ? 32'h0000_0203 : 32'h0000_0300;
        st_size  = SPLIT_EN ? 2'b01 : 2'b10;
        st_data  = 32'h0000_1234;
        step();
        st_valid = 1'b0;
        if (SPLIT_EN) begin
            m_ready = 1'b1;
            step();
            m_ready  = 1'b0;
            m_bvalid = 1'b1;
            step();
            m_bvalid = 1'b0;
            check("pre_reset_beat1_addr", m_addr, 32'h0000_0204);
        end
        check("pre_reset_valid", m_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_reset", {st_ready, st_done, st_err, st_misalign, m_valid}, 5'b10000);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic [1:0]  r0, r1;
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            sz = 2'($urandom_range(0, 3));
            r0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_store(a, sz, $urandom, $urandom_range(0, 3), $urandom_range(0, 10), r0, r1);
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_split_ctrl.md
Name: store_split_ctrl

Overview:
- Store-path controller between the CPU MEM stage and the data-memory write port.
- Accepts one store request (address, size, data) and sequences the byte-lane alignment of strobe and data onto a word-aligned write port.
- Splits a store that crosses a 32-bit word boundary into two write beats, each with its own write/response handshake.
- Reports completion, bus error or misalignment back to the CPU, which stalls until then.

Parameters:
- RESP_TIMEOUT, 0: max cycles to wait for a write response in a RESP state; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; RESP_TIMEOUT must be less than 2**TO_W.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  CPU store request valid
- st_ready  output  1  controller can accept a request; high only in IDLE
- st_addr  input  32  byte address
- st_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- st_data  input  32  store data, right-justified
- st_done  output  1  one-cycle pulse: store completed OK
- st_err  output  1  one-cycle pulse: bus error, timeout or illegal size
- st_misalign  output  1  one-cycle pulse: boundary-crossing store rejected (macro off only)
- m_valid  output  1  write beat valid; carries addr, strobe and data together
- m_ready  input  1  memory accepts the beat
- m_addr  output  32  word-aligned address, bits [1:0] = 00
- m_wstrb  output  4  byte-lane write enables
- m_wdata  output  32  lane-aligned write data
- m_bvalid  input  1  write response valid
- m_bresp  input  2  00 OK; any other value is an error
- m_bready  output  1  controller accepts the response

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately: no replay, no done or err pulse. The memory side is reset in the same domain.
- Accept: a request is accepted on st_valid & st_ready. Size, address and data are registered on acceptance. st_ready = (state == IDLE).
- Lane generation:
  - off = addr[1:0]; base strobe = 0001 / 0011 / 1111 for byte / half / word.
  - s7 = base << off (7 bits); d64 = {32'b0, data} << (8*off).
  - Beat0: strobe s7[3:0], data d64[31:0], m_addr = {addr[31:2], 2'b00}.
  - split = |s7[6:4].
  - Beat1: strobe {1'b0, s7[6:4]}, data d64[63:32], m_addr = {addr[31:2] + 1, 2'b00}. The address wraps 0xFFFFFFFC -> 0x00000000.
- FSM states: IDLE, SEND0, RESP0, SEND1, RESP1.
- IDLE:
  - Accept with size 11: stay in IDLE; pulse st_err next cycle; no bus activity.
  - Accept with split = 1 and macro off: pulse st_misalign next cycle; no bus activity.
  - Otherwise go to SEND0.
- SEND0 / SEND1:
  - m_valid = 1. m_addr, m_wstrb and m_wdata are held stable until m_ready.
  - On m_ready, go to the matching RESP state and clear the counter.
- RESP0 / RESP1:
  - m_bready = 1.
  - On m_bvalid with bresp != 00: go to IDLE and pulse st_err; beat1 is never issued.
  - On m_bvalid OK in RESP0 with split: go to SEND1.
  - On m_bvalid OK otherwise: go to IDLE and pulse st_done.
  - If RESP_TIMEOUT != 0 and the counter reaches RESP_TIMEOUT with no m_bvalid: go to IDLE and pulse st_err.
  - m_bvalid arriving in the same cycle the counter hits the limit: the response wins.
- Pulse timing: st_done, st_err and st_misalign are registered and assert in the first IDLE cycle. A new request may be accepted in that same cycle.
- Latency: aligned store with zero-wait memory = accept at T0, m_valid at T1, m_bvalid at T2, st_done at T3.
- Invariants: at most one beat is outstanding. m_bvalid outside RESP states is ignored.

Optional Feature:
- Macro: STORE_SPLIT_EN.
- Defined: boundary-crossing stores are split into two beats as above. st_misalign is tied 0.
- Undefined: SEND1 and RESP1 are removed. Crossing stores are rejected with an st_misalign pulse and never reach the bus.

Decomposition:
- Shared package store_pkg:
  - st_size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
  - st_state_e
  - BRESP_OKAY = 2'b00
- Sub-module store_lane_gen: combinational. Inputs off, size, data; outputs the two strobes, the two data words and the split flag. It is the natural unit to unit-test on its own.

Test Plan:
- Word 0xDEADBEEF to 0x100, zero-wait memory -> one beat: addr 0x100, strb 1111, data 0xDEADBEEF; st_done at T3.
- Byte 0xAB to 0x103 -> addr 0x100, strb 1000, data 0xAB000000; split = 0; st_done.
- Half 0x1234 to 0x203 (macro on):
  - beat0: addr 0x200, strb 1000, data 0x34000000
  - beat1: addr 0x204, strb 0001, data 0x00000012
  - single st_done after the second response.
- Word 0xCAFEF00D to 0xFFFFFFFE -> beat0 strb 1100 at 0xFFFFFFFC; beat1 strb 0011 at 0x00000000 (wrap).
- Split store, beat0 bresp = 10 -> st_err pulse; m_valid never reasserts; st_ready returns high. Separately, RESP_TIMEOUT = 16 with no bvalid -> st_err exactly 16 cycles into RESP0.
- Macro off: half to 0x203 -> st_misalign pulse, no m_valid. Separately, size 11 -> st_err, no bus activity. rst_n low while in SEND1 -> all outputs 0 immediately.
